// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer output collector and its argmax reducer.
package layer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } coll_state_t;

  // Index width for n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_reduce.sv
// Combinational signed max/argmax over N entries; ties go to the lowest index.
// Only built when LAYER_OUT_COLLECTOR_ARGMAX_EN is defined.
`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
module argmax_reduce
  import layer_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int IDX_W = idx_width(N)
) (
  input  logic signed [WIDTH-1:0] vals [N],
  output logic        [IDX_W-1:0] max_idx,
  output logic signed [WIDTH-1:0] max_val
);

  always_comb begin
    max_idx = '0;
    max_val = vals[0];
    // Strict compare keeps the earliest index on a tie.
    for (int i = 1; i < N; i++) begin
      if (vals[i] > max_val) begin
        max_val = vals[i];
        max_idx = IDX_W'(i);
      end
    end
  end

endmodule
`endif

// File: rtl/layer_out_collector.sv
// Gathers per-neuron results, then drains them in index order as a valid/ready stream.
// Optional argmax outputs are enabled by LAYER_OUT_COLLECTOR_ARGMAX_EN.
module layer_out_collector
  import layer_pkg::*;
#(
  parameter int NUM_OUTPUTS = 4,
  parameter int WIDTH       = 8,
  parameter int FRAC_BITS   = 3,
  localparam int IDX_W      = idx_width(NUM_OUTPUTS)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] VALUES_IN [NUM_OUTPUTS],
  input  logic [0:0]              VALIDS_IN [NUM_OUTPUTS],
  output logic signed [WIDTH-1:0] DATA_OUT,
  output logic [IDX_W-1:0]        INDEX_OUT,
  output logic                    VALID_OUT,
  input  logic                    READY_IN,
  output logic                    LAST_OUT,
`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
  output logic [IDX_W-1:0]        ARGMAX_OUT,
  output logic signed [WIDTH-1:0] ARGMAX_VALUE_OUT,
`endif
  output logic                    OVERRUN_OUT
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);

  // Fixed-point position is carried for interface consistency only.
  logic [31:0] unused_frac_bits;
  assign unused_frac_bits = FRAC_BITS;

  coll_state_t             state_q;
  logic [NUM_OUTPUTS-1:0]  captured_q;
  logic [NUM_OUTPUTS-1:0]  valid_vec;
  logic [NUM_OUTPUTS-1:0]  fresh;
  logic [NUM_OUTPUTS-1:0]  cap_next;
  logic [IDX_W-1:0]        idx_q;
  logic                    overrun_q;
  logic signed [WIDTH-1:0] entry_q    [NUM_OUTPUTS];
  logic signed [WIDTH-1:0] entry_next [NUM_OUTPUTS];

  always_comb begin
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      valid_vec[i] = VALIDS_IN[i][0];
    end
    fresh    = valid_vec & ~captured_q;
    cap_next = captured_q | valid_vec;
    // Buffer view including this cycle's first captures, so argmax sees the complete frame.
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      entry_next[i] = fresh[i] ? VALUES_IN[i] : entry_q[i];
    end
  end

`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
  logic [IDX_W-1:0]        am_idx;
  logic signed [WIDTH-1:0] am_val;
  logic [IDX_W-1:0]        argmax_q;
  logic signed [WIDTH-1:0] argmax_val_q;

  argmax_reduce #(
    .N     (NUM_OUTPUTS),
    .WIDTH (WIDTH)
  ) u_argmax (
    .vals    (entry_next),
    .max_idx (am_idx),
    .max_val (am_val)
  );

  assign ARGMAX_OUT       = argmax_q;
  assign ARGMAX_VALUE_OUT = argmax_val_q;
`endif

  // Buffer needs no reset; contents are only observed in DRAIN after a full capture.
  always_ff @(posedge CLK) begin
    if (state_q == COLLECT) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        entry_q[i] <= entry_next[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= COLLECT;
      captured_q <= '0;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
      argmax_q     <= '0;
      argmax_val_q <= '0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          if (|(valid_vec & captured_q)) begin
            overrun_q <= 1'b1;
          end
          captured_q <= cap_next;
          if (&cap_next) begin
            state_q <= DRAIN;
            idx_q   <= '0;
`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
            argmax_q     <= am_idx;
            argmax_val_q <= am_val;
`endif
          end
        end
        DRAIN: begin
          // Pulses while draining have nowhere to go.
          if (|valid_vec) begin
            overrun_q <= 1'b1;
          end
          if (READY_IN) begin
            if (idx_q == LAST_IDX) begin
              state_q    <= COLLECT;
              captured_q <= '0;
              idx_q      <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign VALID_OUT   = (state_q == DRAIN);
  assign DATA_OUT    = VALID_OUT ? entry_q[idx_q] : '0;
  assign INDEX_OUT   = idx_q;
  assign LAST_OUT    = VALID_OUT && (idx_q == LAST_IDX);
  assign OVERRUN_OUT = overrun_q;

endmodule

// File: tb/tb_layer_out_collector.sv
// Directed bench for layer_out_collector with a beat scoreboard; argmax checks under LAYER_OUT_COLLECTOR_ARGMAX_EN.
module tb_layer_out_collector;

  localparam int N = 4;
  localparam int W = 8;

  logic                CLK = 1'b0;
  logic                RST;
  logic signed [W-1:0] VALUES_IN [N];
  logic [0:0]          VALIDS_IN [N];
  logic signed [W-1:0] DATA_OUT;
  logic [1:0]          INDEX_OUT;
  logic                VALID_OUT;
  logic                READY_IN;
  logic                LAST_OUT;
  logic                OVERRUN_OUT;
`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
  logic [1:0]          ARGMAX_OUT;
  logic signed [W-1:0] ARGMAX_VALUE_OUT;
`endif

  layer_out_collector #(
    .NUM_OUTPUTS (N),
    .WIDTH       (W),
    .FRAC_BITS   (3)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .VALUES_IN   (VALUES_IN),
    .VALIDS_IN   (VALIDS_IN),
    .DATA_OUT    (DATA_OUT),
    .INDEX_OUT   (INDEX_OUT),
    .VALID_OUT   (VALID_OUT),
    .READY_IN    (READY_IN),
    .LAST_OUT    (LAST_OUT),
`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
    .ARGMAX_OUT       (ARGMAX_OUT),
    .ARGMAX_VALUE_OUT (ARGMAX_VALUE_OUT),
`endif
    .OVERRUN_OUT (OVERRUN_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]          idx;
    logic signed [W-1:0] data;
    logic                last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Queue the first 'count' beats of a frame in index order.
  task automatic push_frame(input logic signed [W-1:0] v0, v1, v2, v3, input int count);
    logic signed [W-1:0] v [N];
    beat_t b;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int i = 0; i < count; i++) begin
      b.idx  = 2'(i);
      b.data = v[i];
      b.last = (i == N - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse(input int i, input logic signed [W-1:0] v);
    VALIDS_IN[i] = 1'b1;
    VALUES_IN[i] = v;
    tick();
    VALIDS_IN[i] = 1'b0;
  endtask

  task automatic load_all(input logic signed [W-1:0] v0, v1, v2, v3);
    VALUES_IN[0] = v0; VALUES_IN[1] = v1; VALUES_IN[2] = v2; VALUES_IN[3] = v3;
    for (int i = 0; i < N; i++) VALIDS_IN[i] = 1'b1;
    tick();
    for (int i = 0; i < N; i++) VALIDS_IN[i] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 50 && VALID_OUT; k++) tick();
    check({tag, "_drained"}, VALID_OUT, 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted beat must match the head of the expected queue.
  always @(negedge CLK) begin
    if (!RST && VALID_OUT && READY_IN) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_index", INDEX_OUT, e.idx);
        check("beat_data", DATA_OUT, e.data);
        check("beat_last", LAST_OUT, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST      = 1'b1;
    READY_IN = 1'b1;
    for (int i = 0; i < N; i++) begin
      VALIDS_IN[i] = 1'b0;
      VALUES_IN[i] = '0;
    end
    repeat (2) tick();
    check("rst_valid", VALID_OUT, 0);
    check("rst_data", DATA_OUT, 0);
    check("rst_index", INDEX_OUT, 0);
    check("rst_last", LAST_OUT, 0);
    check("rst_overrun", OVERRUN_OUT, 0);
`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
    check("rst_argmax", ARGMAX_OUT, 0);
    check("rst_argmax_val", ARGMAX_VALUE_OUT, 0);
`endif
    RST = 1'b0;
    tick();

    // All four at once, free-running drain.
    push_frame(8'h10, 8'hF8, 8'h7F, 8'h01, 4);
    load_all(8'h10, 8'hF8, 8'h7F, 8'h01);
    check("t1_valid_rise", VALID_OUT, 1);
    check("t1_first_index", INDEX_OUT, 0);
    repeat (4) tick();
    check("t1_valid_fall", VALID_OUT, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Staggered arrivals 3,0,2,1 at t, t+2, t+5, t+9.
    push_frame(8'h21, 8'h22, 8'h23, 8'h24, 4);
    pulse(3, 8'h24);
    tick();
    check("t2_idle_a", VALID_OUT, 0);
    pulse(0, 8'h21);
    repeat (2) tick();
    check("t2_idle_b", VALID_OUT, 0);
    pulse(2, 8'h23);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_idle_c", VALID_OUT, 0);
    end
    pulse(1, 8'h22);
    check("t2_valid_rise", VALID_OUT, 1);
    check("t2_first_index", INDEX_OUT, 0);
    wait_idle("t2");

    // Backpressure on beat 1 for three cycles.
    push_frame(8'h31, 8'h32, 8'h33, 8'h34, 4);
    load_all(8'h31, 8'h32, 8'h33, 8'h34);
    tick();
    READY_IN = 1'b0;
    check("t3_hold_index", INDEX_OUT, 1);
    check("t3_hold_data", DATA_OUT, 8'h32);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_stall_valid", VALID_OUT, 1);
      check("t3_stall_index", INDEX_OUT, 1);
      check("t3_stall_data", DATA_OUT, 8'h32);
    end
    READY_IN = 1'b1;
    wait_idle("t3");

    // Duplicate capture on neuron 2 keeps the first value.
    check("t4_overrun_clear", OVERRUN_OUT, 0);
    pulse(2, 8'h05);
    pulse(2, 8'h33);
    check("t4_overrun_set", OVERRUN_OUT, 1);
    check("t4_still_collect", VALID_OUT, 0);
    push_frame(8'h41, 8'h42, 8'h05, 8'h44, 4);
    VALUES_IN[0] = 8'h41; VALUES_IN[1] = 8'h42; VALUES_IN[3] = 8'h44;
    VALIDS_IN[0] = 1'b1; VALIDS_IN[1] = 1'b1; VALIDS_IN[3] = 1'b1;
    tick();
    for (int i = 0; i < N; i++) VALIDS_IN[i] = 1'b0;
    wait_idle("t4");

    // Pulse during drain, then reset mid-frame after beat 1.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5_overrun_after_rst", OVERRUN_OUT, 0);
    push_frame(8'h51, 8'h52, 8'h53, 8'h54, 2);
    load_all(8'h51, 8'h52, 8'h53, 8'h54);
    VALIDS_IN[0] = 1'b1;
    VALUES_IN[0] = 8'h7E;
    tick();
    VALIDS_IN[0] = 1'b0;
    check("t5_overrun_drain", OVERRUN_OUT, 1);
    check("t5_index_after_beat0", INDEX_OUT, 1);
    tick();
    RST = 1'b1;
    tick();
    check("t5_rst_valid", VALID_OUT, 0);
    check("t5_rst_overrun", OVERRUN_OUT, 0);
    check("t5_rst_index", INDEX_OUT, 0);
    check("t5_rst_last", LAST_OUT, 0);
    RST = 1'b0;
    check("t5_beats_before_rst", exp_q.size(), 0);
    push_frame(8'h61, 8'h62, 8'h63, 8'h64, 4);
    load_all(8'h61, 8'h62, 8'h63, 8'h64);
    check("t5_refill_index", INDEX_OUT, 0);
    check("t5_refill_data", DATA_OUT, 8'h61);
    wait_idle("t5");

`ifdef LAYER_OUT_COLLECTOR_ARGMAX_EN
    push_frame(8'sd5, 8'sd9, 8'sd9, -8'sd3, 4);
    load_all(8'sd5, 8'sd9, 8'sd9, -8'sd3);
    check("am1_idx", ARGMAX_OUT, 1);
    check("am1_val", ARGMAX_VALUE_OUT, 8'sd9);
    repeat (2) tick();
    check("am1_idx_held", ARGMAX_OUT, 1);
    check("am1_val_held", ARGMAX_VALUE_OUT, 8'sd9);
    wait_idle("am1");
    push_frame(-8'sd8, -8'sd2, -8'sd5, -8'sd2, 4);
    load_all(-8'sd8, -8'sd2, -8'sd5, -8'sd2);
    check("am2_idx", ARGMAX_OUT, 1);
    check("am2_val", ARGMAX_VALUE_OUT, -8'sd2);
    wait_idle("am2");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_out_collector.md
Name: layer_out_collector

Overview:
- Receiving end of a fully-connected layer's output interface.
- Captures per-neuron results, which may complete on different cycles, into a local buffer.
- Once every neuron has reported, drains the buffer as a serial valid/ready stream, one neuron per beat, in index order.
- Sits between one layer's outputs and the next serial consumer: the next-layer loader, the output FIFO or the host readback.

Parameters:
NUM_OUTPUTS  4  number of neurons (buffer entries); must be >= 2
WIDTH  8  signed fixed-point data width
FRAC_BITS  3  fractional bits; carried for consistency, no arithmetic depends on it
IDX_W  $clog2(NUM_OUTPUTS)  index width (derived, do not override)

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
VALUES_IN  in  signed [WIDTH-1:0] x NUM_OUTPUTS (unpacked)  per-neuron result values
VALIDS_IN  in  [0:0] x NUM_OUTPUTS (unpacked)  per-neuron single-cycle valid pulses
DATA_OUT  out  signed WIDTH  current beat value
INDEX_OUT  out  IDX_W  neuron index of current beat
VALID_OUT  out  1  beat valid
READY_IN  in  1  downstream ready
LAST_OUT  out  1  high on beat with INDEX_OUT == NUM_OUTPUTS-1
OVERRUN_OUT  out  1  sticky protocol-error flag

Behaviour:
- All state changes on rising CLK edges.
- RST is synchronous and active-high, and dominates everything, including mid-drain:
  - state = COLLECT, captured mask = 0, drain index = 0
  - VALID_OUT = 0, DATA_OUT = 0, INDEX_OUT = 0, LAST_OUT = 0, OVERRUN_OUT = 0
  - buffer contents become don't-care
- States: COLLECT, DRAIN.
- COLLECT:
  - For each i with VALIDS_IN[i] = 1 and captured[i] = 0: buf[i] <= VALUES_IN[i]; captured[i] <= 1.
  - For each i with VALIDS_IN[i] = 1 and captured[i] = 1: value ignored (first capture kept); OVERRUN_OUT <= 1.
  - If the mask including this cycle's captures is all ones: next state DRAIN, index 0.
  - Simultaneous valids are captured in the same cycle.
- Latency: the last missing valid arriving at edge t gives VALID_OUT = 1 in the cycle after t. Minimum 1 cycle.
- DRAIN:
  - VALID_OUT = 1; DATA_OUT = buf[idx]; INDEX_OUT = idx; LAST_OUT = (idx == NUM_OUTPUTS-1).
  - On VALID_OUT && READY_IN: idx++.
  - On VALID_OUT && READY_IN with LAST_OUT: captured <= 0, idx <= 0, state <= COLLECT, VALID_OUT low next cycle.
  - While READY_IN = 0, DATA_OUT, INDEX_OUT and LAST_OUT hold stable; no combinational path from READY_IN to VALID_OUT.
  - Any VALIDS_IN pulse during DRAIN, including the cycle of the last handshake, is dropped and sets OVERRUN_OUT.
- Throughput: READY_IN held high gives NUM_OUTPUTS consecutive beats, then at least 1 COLLECT cycle before the next frame.
- OVERRUN_OUT clears only on RST.
- Outputs are driven from registers or from a mux of registered buffer and registered index; no input-to-output combinational path.

Optional Feature:
- Macro: LAYER_OUT_COLLECTOR_ARGMAX_EN.
- Defined:
  - Adds ports ARGMAX_OUT (out, IDX_W) and ARGMAX_VALUE_OUT (out, signed WIDTH).
  - Both registered on the COLLECT->DRAIN transition and held stable for the whole DRAIN.
  - Value is the index and value of the signed maximum of the complete buffer; ties resolve to the lowest index.
  - Both reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package layer_pkg:
  - collector state enum (COLLECT, DRAIN)
  - index-width helper function
- Sub-module argmax_reduce (parameterised by N and WIDTH): combinational signed max/argmax with lowest-index tie-break. Instantiated only under LAYER_OUT_COLLECTOR_ARGMAX_EN.
- Everything else stays in one module.

Test Plan:
- All 4 valids in cycle t with values {0x10, 0xF8, 0x7F, 0x01}, READY_IN = 1 -> beats at t+1..t+4 with INDEX 0..3 and DATA 0x10, 0xF8, 0x7F, 0x01; LAST_OUT only at t+4; VALID_OUT = 0 at t+5.
- Staggered valids for neurons 3, 0, 2, 1 at t, t+2, t+5, t+9 -> VALID_OUT stays 0 through t+9 and rises at t+10; beats still in index order 0..3.
- Backpressure: READY_IN low for 3 cycles on beat index 1 -> DATA_OUT and INDEX_OUT = 1 stable for 4 cycles; no beat lost or duplicated.
- Duplicate valid on neuron 2 (0x05, then 0x33) before frame completes -> OVERRUN_OUT = 1; drained beat 2 = 0x05.
- Valid on neuron 0 during DRAIN, then RST asserted after beat 1 -> OVERRUN_OUT = 1 before reset; one cycle after RST, VALID_OUT = 0 and OVERRUN_OUT = 0; next full frame drains correctly from index 0.
- With LAYER_OUT_COLLECTOR_ARGMAX_EN defined: values {5, 9, 9, -3} -> ARGMAX_OUT = 1, ARGMAX_VALUE_OUT = 9 from the first DRAIN cycle; values {-8, -2, -5, -2} -> ARGMAX_OUT = 1.
